// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control unit and the ALU:
// FSM state encodings, opcode/funct fields, ALU codes and instruction classification.
package riscv_pkg;

    typedef enum logic [3:0] {
        BUSCA      = 4'b0000,
        DECODIFICA = 4'b0001,
        INICIO     = 4'b0100,
        EXEC       = 4'b0101,
        EXEC_B     = 4'b0110,
        MEM        = 4'b0111,
        ESCRITA    = 4'b1000,
        DESVIO     = 4'b1001,
        PARADO     = 4'b1111
    } estado_e;

    typedef enum logic [2:0] {
        I_ILEGAL,
        I_R,
        I_ADDI,
        I_LW,
        I_SW,
        I_BEQ,
        I_BNE
    } instr_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_BNE  = 4'b1111;

    // R-type operation code; returns legal=0 for unsupported funct7/funct3 pairs.
    function automatic logic [4:0] alu_r(input logic [6:0] f7, input logic [2:0] f3);
        logic       legal;
        logic [3:0] code;
        legal = 1'b1;
        code  = '0;
        if (f7 == F7_BASE) begin
            case (f3)
                F3_ADD_SUB: code = ALU_ADD;
                F3_AND:     code = ALU_AND;
                F3_OR:      code = ALU_OR;
                F3_XOR:     code = ALU_XOR;
                F3_SRL:     code = ALU_SRL;
                default:    legal = 1'b0;
            endcase
        end else if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
            code = ALU_SUB;
        end else begin
            legal = 1'b0;
        end
        return {legal, code};
    endfunction

    function automatic instr_e classifica(input logic [31:0] ir);
        logic [4:0] r;
        instr_e     t;
        r = alu_r(ir[31:25], ir[14:12]);
        t = I_ILEGAL;
        case (ir[6:0])
            OP_R:      if (r[4]) t = I_R;
            OP_IMM:    if (ir[14:12] == F3_ADDI) t = I_ADDI;
            OP_LOAD:   if (ir[14:12] == F3_WORD) t = I_LW;
            OP_STORE:  if (ir[14:12] == F3_WORD) t = I_SW;
            OP_BRANCH: begin
                if (ir[14:12] == F3_BEQ) t = I_BEQ;
                else if (ir[14:12] == F3_BNE) t = I_BNE;
            end
            default:   t = I_ILEGAL;
        endcase
        return t;
    endfunction

    function automatic logic [3:0] alu_codigo(input instr_e t, input logic [31:0] ir);
        logic [4:0] r;
        logic [3:0] code;
        r = alu_r(ir[31:25], ir[14:12]);
        case (t)
            I_R:         code = r[3:0];
            I_ADDI:      code = ALU_ADDI;
            I_LW, I_SW:  code = ALU_ADD;
            I_BEQ:       code = ALU_SUB;
            I_BNE:       code = ALU_BNE;
            default:     code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Immediate generator: sign-extends the I/S/B immediate of ir and presents it
// as sign flag plus unsigned magnitude.
module gerador_imediato
    import riscv_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] immediate,
    output logic        negativo
);

    instr_e      tipo;
    logic [31:0] ext;

    assign tipo = classifica(ir);

    always_comb begin
        case (tipo)
            I_ADDI, I_LW: ext = {{20{ir[31]}}, ir[31:20]};
            I_SW:         ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            I_BEQ, I_BNE: ext = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:      ext = '0;
        endcase
    end

    // Magnitude of the most negative B offset (-4096) still fits in 32 bits.
    assign negativo  = ext[31];
    assign immediate = ext[31] ? (~ext + 32'd1) : ext;

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control unit: state register plus instruction register,
// with all datapath controls decoded combinationally from (estado, ir).
module controle_multiciclo
    import riscv_pkg::*;
#(
    parameter bit HALT_ON_ERRO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrucao,
    input  logic        pcsrc,
    output logic [3:0]  estado,
    output logic        alusrc,
    output logic [3:0]  alucontrol,
    output logic        branch,
    output logic [31:0] immediate,
    output logic        negativo,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        erro
);

    estado_e     estado_r;
    logic [31:0] ir;
    instr_e      tipo;
    logic        ativo;

    assign tipo = classifica(ir);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_r <= INICIO;
            ir       <= '0;
        end else begin
            case (estado_r)
                INICIO:     estado_r <= BUSCA;
                BUSCA: begin
                    ir       <= instrucao;
                    estado_r <= DECODIFICA;
                end
                DECODIFICA: begin
                    case (tipo)
                        I_ILEGAL:     estado_r <= HALT_ON_ERRO ? PARADO : BUSCA;
                        I_BEQ, I_BNE: estado_r <= EXEC_B;
                        default:      estado_r <= EXEC;
                    endcase
                end
                EXEC:       estado_r <= (tipo == I_LW || tipo == I_SW) ? MEM : ESCRITA;
                MEM:        estado_r <= (tipo == I_LW) ? ESCRITA : BUSCA;
                ESCRITA:    estado_r <= BUSCA;
                EXEC_B:     estado_r <= DESVIO;
                DESVIO:     estado_r <= BUSCA;
                PARADO:     estado_r <= PARADO;
                default:    estado_r <= INICIO;
            endcase
        end
    end

    assign estado = estado_r;

    always_comb begin
        ativo = (estado_r == DECODIFICA) || (estado_r == EXEC) || (estado_r == EXEC_B) ||
                (estado_r == MEM) || (estado_r == ESCRITA) || (estado_r == DESVIO);
        alusrc     = ativo && (tipo == I_ADDI || tipo == I_LW || tipo == I_SW ||
                               tipo == I_BEQ || tipo == I_BNE);
        alucontrol = ativo ? alu_codigo(tipo, ir) : '0;
        irwrite    = (estado_r == BUSCA);
        pcwrite    = (estado_r == BUSCA) || (estado_r == DESVIO && pcsrc);
        memread    = (estado_r == MEM) && (tipo == I_LW);
        memwrite   = (estado_r == MEM) && (tipo == I_SW);
        regwrite   = (estado_r == ESCRITA);
        memtoreg   = (estado_r == ESCRITA) && (tipo == I_LW);
        branch     = (estado_r == EXEC_B) || (estado_r == DESVIO);
        erro       = (estado_r == DECODIFICA) && (tipo == I_ILEGAL);
    end

    gerador_imediato u_imm (
        .ir        (ir),
        .immediate (immediate),
        .negativo  (negativo)
    );

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have parameter HALT_ON_ERRO, default 0: 1 = illegal opcode parks FSM in PARADO until reset; 0 = illegal opcode returns to BUSCA.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port instrucao  input  32  instruction word from memory, sampled in BUSCA.
REQ-006 SHALL have port pcsrc  input  1  ALU branch-taken flag (aluresult1 & branch).
REQ-007 SHALL have port estado  output  4  current FSM state, drives ALU state input.
REQ-008 SHALL have port alusrc  output  1  ALU operand B select: 1 = immediate path.
REQ-009 SHALL have port alucontrol  output  4  ALU operation code.
REQ-010 SHALL have port branch  output  1  branch instruction in progress.
REQ-011 SHALL have port immediate  output  32  immediate magnitude (unsigned absolute value).
REQ-012 SHALL have port negativo  output  1  immediate sign (1 = negative).
REQ-013 SHALL have ports regwrite, memread, memwrite, memtoreg, irwrite, pcwrite, erro  output  1 each  datapath strobes.

Function
REQ-014 SHALL hold a 32-bit internal instruction register ir, loaded from instrucao on the clock edge leaving BUSCA.
REQ-015 SHALL encode states: INICIO 0100, BUSCA 0000, DECODIFICA 0001, EXEC 0101, EXEC_B 0110, MEM 0111, ESCRITA 1000, DESVIO 1001, PARADO 1111.
REQ-016 SHALL transition: INICIO->BUSCA->DECODIFICA; DECODIFICA->EXEC (R, addi, lw, sw), ->EXEC_B (beq, bne), ->BUSCA or PARADO (illegal); EXEC->ESCRITA (R, addi), ->MEM (lw, sw); MEM->ESCRITA (lw), ->BUSCA (sw); ESCRITA->BUSCA; EXEC_B->DESVIO->BUSCA; PARADO->PARADO.
REQ-017 SHALL give cycles per instruction: R/addi/sw/beq/bne 4, lw 5, illegal 2.
REQ-018 SHALL decode legal opcodes only: 0110011 R, 0010011 funct3 000 addi, 0000011 funct3 010 lw, 0100011 funct3 010 sw, 1100011 funct3 000 beq / 001 bne; anything else is illegal.
REQ-019 SHALL map R-type alucontrol (alusrc 0): add 0010, sub (funct7 0100000) 0110, and 0000, or 0001, xor 0100, srl 0101; other funct3/funct7 combinations are illegal.
REQ-020 SHALL map alusrc=1: lw/sw 0010, addi 0011, beq 0110, bne 1111.
REQ-021 SHALL drive alusrc/alucontrol from ir in DECODIFICA through ESCRITA/DESVIO, and drive 0 in INICIO, BUSCA and PARADO.
REQ-022 SHALL drive strobes: irwrite and pcwrite in BUSCA; memread in MEM for lw; memwrite in MEM for sw; regwrite in ESCRITA; memtoreg in ESCRITA for lw; branch in EXEC_B and DESVIO; pcwrite in DESVIO only when pcsrc=1; erro for one cycle in DECODIFICA on illegal opcode.
REQ-023 SHALL derive the immediate from ir by format (I for addi/lw, S for sw, B with bit0=0 for branches; 0 for R), sign-extend it, output negativo = sign bit and immediate = two's-complement absolute value; -4096 (B min) SHALL yield immediate 4096, negativo 1.
REQ-024 SHALL make outputs combinational from (estado, ir) only; estado and ir are the only state.

Reset
REQ-025 SHALL, when rst_n is low at a rising edge, set estado=INICIO (0100) and ir=0; all outputs read 0 except estado.
REQ-026 SHALL abort any instruction in progress on reset, with no strobe asserted in the following cycle.

Structure
REQ-027 SHALL place state encodings, opcode/funct constants and alucontrol codes in shared package riscv_pkg, also used by the ALU.
REQ-028 SHALL implement immediate generation as sub-module gerador_imediato (ir in; immediate, negativo out).

Verification
REQ-029 SHALL cover reset release then add x3,x1,x2 (0x002081B3) -> estado 0100,0000,0001,0101,1000,0000; alucontrol 0010, alusrc 0; regwrite only in 1000.
REQ-030 SHALL cover lw x5,-8(x2) (0xFF812283) -> 5-cycle sequence via 0111; immediate 8, negativo 1, alucontrol 0010, memread in 0111, memtoreg+regwrite in 1000.
REQ-031 SHALL cover beq x1,x2,+16 (0x00208863) with pcsrc=1 in DESVIO -> alucontrol 0110, branch high in 0110/1001, pcwrite in 1001; repeat with pcsrc=0 -> no pcwrite in 1001.
REQ-032 SHALL cover opcode 0x00000000 with HALT_ON_ERRO=0 -> erro pulse in 0001, back to 0000; with HALT_ON_ERRO=1 -> estado stuck at 1111, all strobes 0, until rst_n low.
REQ-033 SHALL cover rst_n asserted during 0111 of sw -> next cycle estado 0100, memwrite 0, then normal fetch.
